// File: rtl/eth_fcs_engine.sv
`default_nettype none
// ============================================================================
//  Module   : eth_fcs_engine
//  Purpose  : Ethernet CRC-32 FCS generator (MODE=0) or checker (MODE=1)
//             over DATA_W-bit LSB-first symbols. Optional bad-frame counter
//             is built when ETH_FCS_ERR_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module eth_fcs_engine #(
    parameter int DATA_W = 2,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [31:0]       crc_out,
    output logic              fcs_done,
    output logic              fcs_ok,
    output logic [15:0]       err_cnt
);

    localparam logic [31:0] c_POLY     = 32'hEDB88320;
    localparam logic [31:0] c_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] c_RESIDUE  = 32'hDEBB20E3;
    localparam int          c_FCS_SYMS = 32 / DATA_W;
    localparam logic [4:0]  c_FCS_LAST = 5'(c_FCS_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2
    } state_t;

    // A checker never appends, so end-of-frame returns straight to IDLE.
    localparam state_t c_EOF_STATE = (MODE == 0) ? FCS : IDLE;

    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic [DATA_W-1:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < DATA_W; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ c_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_crc;
    logic [31:0]         w_crc_next;
    logic [31:0]         w_fcs_word;
    logic [4:0]          r_fcs_cnt;
    logic                w_accept;
    logic                w_fwd;
    logic                w_emit;
    logic                w_check;
    logic                w_fcs_last;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_fcs_done;
    logic                r_fcs_ok;

    assign in_ready   = (r_state != FCS);
    assign w_accept   = in_valid && in_ready;
    assign w_fcs_word = ~r_crc;
    assign w_fcs_last = (r_fcs_cnt == c_FCS_LAST);
    assign w_check    = (MODE == 1) && w_fwd && in_eof;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_crc_next   = r_crc;
        w_fwd        = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            IDLE: begin
                // Symbols outside a frame are discarded until a start marker.
                if (w_accept && in_sof) begin
                    w_crc_next   = crc_step(c_INIT, in_data);
                    w_fwd        = 1'b1;
                    w_state_next = in_eof ? c_EOF_STATE : DATA;
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_crc_next = crc_step(in_sof ? c_INIT : r_crc, in_data);
                    w_fwd      = 1'b1;
                    if (in_eof)
                        w_state_next = c_EOF_STATE;
                end
            end
            FCS: begin
                w_emit = 1'b1;
                if (w_fcs_last)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc       <= c_INIT;
            r_fcs_cnt   <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_fcs_done  <= 1'b0;
            r_fcs_ok    <= 1'b0;
        end else begin
            r_crc       <= w_crc_next;
            r_fcs_cnt   <= w_emit ? r_fcs_cnt + 5'd1 : 5'd0;
            r_out_valid <= w_fwd || w_emit;
            if (w_fwd)
                r_out_data <= in_data;
            else if (w_emit)
                r_out_data <= w_fcs_word[int'(r_fcs_cnt) * DATA_W +: DATA_W];
            else
                r_out_data <= '0;
            r_out_last  <= w_check || (w_emit && w_fcs_last);
            r_fcs_done  <= w_check;
            if (w_check)
                r_fcs_ok <= (w_crc_next == c_RESIDUE);
        end
    end

`ifdef ETH_FCS_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_err_cnt <= 16'd0;
        else if (w_check && (w_crc_next != c_RESIDUE) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'd0;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign crc_out   = ~r_crc;
    assign fcs_done  = r_fcs_done;
    assign fcs_ok    = r_fcs_ok;

endmodule
`default_nettype wire

// File: tb/tb_eth_fcs_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_fcs_engine
//  Purpose  : Self-checking bench for eth_fcs_engine (GMII/RMII generator and
//             RMII checker instances) against a byte-table CRC-32 model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_fcs_engine;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // sel 0: DATA_W=8 MODE=0, sel 1: DATA_W=2 MODE=0, sel 2: DATA_W=2 MODE=1
    logic       v8 = 0, sof8 = 0, eof8 = 0, rdy8, ov8, ol8, done8, ok8;
    logic [7:0] d8 = 0, od8;
    logic [31:0] crc8;
    logic [15:0] err8;
    logic       v20 = 0, sof20 = 0, eof20 = 0, rdy20, ov20, ol20, done20, ok20;
    logic [1:0] d20 = 0, od20;
    logic [31:0] crc20;
    logic [15:0] err20;
    logic       v21 = 0, sof21 = 0, eof21 = 0, rdy21, ov21, ol21, done21, ok21;
    logic [1:0] d21 = 0, od21;
    logic [31:0] crc21;
    logic [15:0] err21;

    eth_fcs_engine #(.DATA_W(8), .MODE(0)) u_g8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_sof(sof8),
        .in_eof(eof8), .in_ready(rdy8), .out_valid(ov8), .out_data(od8),
        .out_last(ol8), .crc_out(crc8), .fcs_done(done8), .fcs_ok(ok8), .err_cnt(err8));
    eth_fcs_engine #(.DATA_W(2), .MODE(0)) u_g2 (
        .clk(clk), .reset(reset), .in_valid(v20), .in_data(d20), .in_sof(sof20),
        .in_eof(eof20), .in_ready(rdy20), .out_valid(ov20), .out_data(od20),
        .out_last(ol20), .crc_out(crc20), .fcs_done(done20), .fcs_ok(ok20), .err_cnt(err20));
    eth_fcs_engine #(.DATA_W(2), .MODE(1)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(v21), .in_data(d21), .in_sof(sof21),
        .in_eof(eof21), .in_ready(rdy21), .out_valid(ov21), .out_data(od21),
        .out_last(ol21), .crc_out(crc21), .fcs_done(done21), .fcs_ok(ok21), .err_cnt(err21));

    int tests = 0;
    int failed = 0;
    int exp_err = 0;
    logic [31:0] crc_tab[256];
    logic [8:0] q[3][$];
    int last_cnt[3] = '{0, 0, 0};
    int done_cnt = 0;
    int rdy_low = 0;

    always @(negedge clk) begin
        if (ov8)  q[0].push_back({ol8, od8});
        if (ov20) q[1].push_back({ol20, 6'd0, od20});
        if (ov21) q[2].push_back({ol21, 6'd0, od21});
        if (ov8 && ol8)   last_cnt[0]++;
        if (ov20 && ol20) last_cnt[1]++;
        if (ov21 && ol21) last_cnt[2]++;
        if (done21) done_cnt++;
        if (!rdy20) rdy_low++;
    end

    function automatic logic [31:0] crc_of(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
        return ~c;
    endfunction

    function automatic int per_byte(input int sel);
        return (sel == 0) ? 1 : 4;
    endfunction

    // k-th symbol of a 32-bit word / byte for the instance's symbol width
    function automatic logic [7:0] sym_of(input int sel, input logic [31:0] w, input int k);
        if (sel == 0) return 8'((w >> (8 * k)) & 32'hFF);
        return 8'((w >> (2 * k)) & 32'h3);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_sym(input int sel, input logic [7:0] d, input logic sof, input logic eof);
        case (sel)
            0: begin v8 = 1; d8 = d; sof8 = sof; eof8 = eof; end
            1: begin v20 = 1; d20 = d[1:0]; sof20 = sof; eof20 = eof; end
            default: begin v21 = 1; d21 = d[1:0]; sof21 = sof; eof21 = eof; end
        endcase
        tick();
        v8 = 0; sof8 = 0; eof8 = 0;
        v20 = 0; sof20 = 0; eof20 = 0;
        v21 = 0; sof21 = 0; eof21 = 0;
    endtask

    task automatic send_bytes(input int sel, input bq_t b, input bit with_eof, input bit gaps);
        int pb;
        pb = per_byte(sel);
        for (int i = 0; i < b.size(); i++) begin
            for (int k = 0; k < pb; k++) begin
                if (gaps && $urandom_range(0, 2) == 0) tick();
                drive_sym(sel, sym_of(sel, {24'd0, b[i]}, k), (i == 0 && k == 0),
                          with_eof && (i == b.size() - 1) && (k == pb - 1));
            end
        end
    endtask

    task automatic wait_last(input int sel, input int base);
        int n;
        n = 0;
        while (last_cnt[sel] == base && n < 100) begin tick(); n++; end
        if (last_cnt[sel] == base) begin
            tests++; failed++;
            $display("FAIL wait_last sel=%0d: got no out_last in 100 cycles, required one", sel);
        end
        tick();
    endtask

    task automatic test_reset();
        v8 = 1; sof8 = 1; v20 = 1; sof20 = 1; v21 = 1; sof21 = 1;
        repeat (3) tick();
        tests++; if ({ov8, ov20, ov21} !== 3'b000) begin failed++;
            $display("FAIL rst_out_valid: got %b required 000", {ov8, ov20, ov21}); end
        tests++; if ({crc8, crc20, crc21} !== 96'd0) begin failed++;
            $display("FAIL rst_crc_out: got %h %h %h required 0", crc8, crc20, crc21); end
        tests++; if ({done21, ok21, err21} !== 18'd0) begin failed++;
            $display("FAIL rst_check_outs: got done=%b ok=%b err=%0d required 0", done21, ok21, err21); end
        tests++; if ({od8, od20, od21, ol8, ol20, ol21} !== 15'd0) begin failed++;
            $display("FAIL rst_out_data: got %h/%h/%h last %b%b%b required 0", od8, od20, od21, ol8, ol20, ol21); end
        v8 = 0; sof8 = 0; v20 = 0; sof20 = 0; v21 = 0; sof21 = 0;
        reset = 0;
        tick();
        tests++; if ({rdy8, rdy20, rdy21} !== 3'b111) begin failed++;
            $display("FAIL rst_in_ready: got %b required 111", {rdy8, rdy20, rdy21}); end
        tests++; if ({ov8, ov20, ov21} !== 3'b000 || crc20 !== 32'd0) begin failed++;
            $display("FAIL rst_ignored_input: got ov=%b crc=%h required 000/0", {ov8, ov20, ov21}, crc20); end
    endtask

    task automatic test_known_w8();
        bq_t b;
        logic [7:0] fcs[4];
        int base;
        fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        b = {};
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        q[0].delete();
        base = last_cnt[0];
        send_bytes(0, b, 1, 0);
        wait_last(0, base);
        tests++; if (crc8 !== 32'hCBF43926) begin failed++;
            $display("FAIL w8_crc_out: got %h required cbf43926", crc8); end
        tests++;
        if (q[0].size() != 13) begin failed++;
            $display("FAIL w8_out_count: got %0d required 13", q[0].size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                logic [8:0] e;
                e = (i < 9) ? {1'b0, b[i]} : {(i == 12), fcs[i - 9]};
                if (q[0][i] !== e) begin failed++;
                    $display("FAIL w8_out_sym[%0d]: got %h required %h", i, q[0][i], e); break; end
            end
        end
    endtask

    task automatic test_known_w2();
        bq_t b;
        int base;
        b = {};
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        q[1].delete();
        base = last_cnt[1];
        rdy_low = 0;
        send_bytes(1, b, 1, 0);
        wait_last(1, base);
        tests++; if (crc20 !== 32'hCBF43926) begin failed++;
            $display("FAIL w2_crc_out: got %h required cbf43926", crc20); end
        tests++; if (rdy_low != 16) begin failed++;
            $display("FAIL w2_ready_low: got %0d cycles required 16", rdy_low); end
        tests++;
        if (q[1].size() != 52) begin failed++;
            $display("FAIL w2_out_count: got %0d required 52", q[1].size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                logic [8:0] e;
                e = {(k == 15), sym_of(1, 32'hCBF43926, k)};
                if (q[1][36 + k] !== e) begin failed++;
                    $display("FAIL w2_fcs_sym[%0d]: got %h required %h", k, q[1][36 + k], e); break; end
            end
        end
    endtask

    task automatic test_reset_in_fcs();
        bq_t b;
        logic [8:0] e;
        int base;
        b = {};
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        base = last_cnt[1];
        send_bytes(1, b, 1, 0);
        tick();
        reset = 1;
        tick();
        reset = 0;
        tests++; if (ov20 !== 1'b0 || crc20 !== 32'd0 || rdy20 !== 1'b1) begin failed++;
            $display("FAIL fcs_reset_state: got ov=%b crc=%h rdy=%b required 0/0/1", ov20, crc20, rdy20); end
        repeat (20) tick();
        tests++; if (last_cnt[1] != base) begin failed++;
            $display("FAIL fcs_reset_abort: got %0d out_last after abort required 0", last_cnt[1] - base); end
        exp_err = 0;
        b = {};
        for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
        q[1].delete();
        base = last_cnt[1];
        send_bytes(1, b, 1, 1);
        wait_last(1, base);
        tests++; if (crc20 !== crc_of(b)) begin failed++;
            $display("FAIL post_reset_crc: got %h required %h", crc20, crc_of(b)); end
        tests++;
        if (q[1].size() != 44) begin failed++;
            $display("FAIL post_reset_count: got %0d required 44", q[1].size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                e = {(k == 15), sym_of(1, crc_of(b), k)};
                if (q[1][28 + k] !== e) begin failed++;
                    $display("FAIL post_reset_fcs[%0d]: got %h required %h", k, q[1][28 + k], e); break; end
            end
        end
    endtask

    task automatic test_restart_gaps();
        for (int it = 0; it < 8; it++) begin
            bq_t a, b;
            logic [8:0] exp[$];
            logic [31:0] fcs, got;
            int sel, base, pb, nf;
            sel = it % 2;
            pb = per_byte(sel);
            nf = (sel == 0) ? 4 : 16;
            a = {}; b = {}; exp = {};
            for (int i = 0; i < $urandom_range(1, 6); i++) a.push_back(8'($urandom));
            for (int i = 0; i < $urandom_range(1, 20); i++) b.push_back(8'($urandom));
            fcs = crc_of(b);
            foreach (a[i]) for (int k = 0; k < pb; k++) exp.push_back({1'b0, sym_of(sel, {24'd0, a[i]}, k)});
            foreach (b[i]) for (int k = 0; k < pb; k++) exp.push_back({1'b0, sym_of(sel, {24'd0, b[i]}, k)});
            for (int k = 0; k < nf; k++) exp.push_back({(k == nf - 1), sym_of(sel, fcs, k)});
            q[sel].delete();
            base = last_cnt[sel];
            drive_sym(sel, 8'($urandom), 0, 0);
            drive_sym(sel, 8'($urandom), 0, 1);
            send_bytes(sel, a, 0, 1);
            send_bytes(sel, b, 1, 1);
            wait_last(sel, base);
            got = (sel == 0) ? crc8 : crc20;
            tests++; if (got !== fcs) begin failed++;
                $display("FAIL restart_crc it=%0d: got %h required %h", it, got, fcs); end
            tests++;
            if (q[sel].size() != exp.size()) begin failed++;
                $display("FAIL restart_count it=%0d: got %0d required %0d", it, q[sel].size(), exp.size());
            end else begin
                foreach (exp[i]) if (q[sel][i] !== exp[i]) begin failed++;
                    $display("FAIL restart_sym it=%0d [%0d]: got %h required %h", it, i, q[sel][i], exp[i]); break; end
            end
        end
    endtask

    task automatic test_check_known(input bit flip);
        bq_t b;
        int d0, l0;
        b = {};
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        b.push_back(8'h26); b.push_back(8'h39); b.push_back(8'hF4); b.push_back(8'hCB);
        if (flip) b[0] = b[0] ^ 8'h01;
        q[2].delete();
        d0 = done_cnt;
        l0 = last_cnt[2];
        send_bytes(2, b, 1, 0);
        tests++; if (done21 !== 1'b1 || ok21 !== !flip) begin failed++;
            $display("FAIL check_result flip=%0d: got done=%b ok=%b required 1/%b", flip, done21, ok21, !flip); end
`ifdef ETH_FCS_ERR_CNT_EN
        if (flip) exp_err++;
`endif
        tick();
        tests++; if (done21 !== 1'b0) begin failed++;
            $display("FAIL check_pulse flip=%0d: got done=%b required 0", flip, done21); end
        repeat (3) tick();
        tests++; if (ok21 !== !flip || err21 !== 16'(exp_err)) begin failed++;
            $display("FAIL check_hold flip=%0d: got ok=%b err=%0d required %b/%0d", flip, ok21, err21, !flip, exp_err); end
        tests++; if (done_cnt - d0 != 1 || last_cnt[2] - l0 != 1 || q[2].size() != 52 || q[2][51][8] !== 1'b1) begin
            failed++;
            $display("FAIL check_stream flip=%0d: got done=%0d last=%0d n=%0d required 1/1/52",
                     flip, done_cnt - d0, last_cnt[2] - l0, q[2].size());
        end
    endtask

    task automatic test_check_random();
        for (int it = 0; it < 8; it++) begin
            bq_t b;
            logic [31:0] fcs;
            bit bad;
            int n;
            b = {};
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            fcs = crc_of(b);
            for (int k = 0; k < 4; k++) b.push_back(sym_of(0, fcs, k));
            bad = ($urandom_range(0, 1) == 1);
            if (bad) begin
                int p;
                p = $urandom_range(0, b.size() - 1);
                b[p] = b[p] ^ (8'h01 << $urandom_range(0, 7));
            end
            send_bytes(2, b, 1, 1);
`ifdef ETH_FCS_ERR_CNT_EN
            if (bad) exp_err++;
`endif
            tests++; if (done21 !== 1'b1 || ok21 !== !bad) begin failed++;
                $display("FAIL rand_check it=%0d: got done=%b ok=%b required 1/%b", it, done21, ok21, !bad); end
            repeat (2) tick();
            tests++; if (err21 !== 16'(exp_err)) begin failed++;
                $display("FAIL rand_err_cnt it=%0d: got %0d required %0d", it, err21, exp_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        #1;
        test_reset();
        test_known_w8();
        test_known_w2();
        test_reset_in_fcs();
        test_restart_gaps();
        test_check_known(1'b0);
        test_check_known(1'b1);
        test_check_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/eth_fcs_engine.md
ETH_FCS_ENGINE -- requirements
Module: eth_fcs_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 2, symbol width in bits; legal values 2, 4, 8 (RMII/MII/GMII).
REQ-002 SHALL have parameter MODE, default 0: 0 = generate and append FCS, 1 = check received FCS.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input symbol valid.
REQ-006 SHALL have port in_data  input  DATA_W  input symbol; bit 0 is first on the wire.
REQ-007 SHALL have port in_sof  input  1  first symbol of frame, qualified by in_valid.
REQ-008 SHALL have port in_eof  input  1  last symbol of frame (MODE=1: last FCS symbol), qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a symbol this cycle.
REQ-010 SHALL have ports out_valid  output  1, out_data  output  DATA_W, out_last  output  1  for the output symbol stream.
REQ-011 SHALL have port crc_out  output  32  running CRC, complemented.
REQ-012 SHALL have ports fcs_done  output  1  one-cycle check pulse, fcs_ok  output  1  check result, err_cnt  output  16  bad-frame count.

Function
REQ-013 SHALL implement CRC-32 with reflected polynomial 0xEDB88320, init 0xFFFFFFFF, right shift, LSB-first, advancing DATA_W bits per accepted symbol in one cycle.
REQ-014 A symbol SHALL be accepted when in_valid && in_ready; while in_valid is low the CRC register holds.
REQ-015 The FSM SHALL have states IDLE, DATA, FCS; FCS SHALL be reachable only when MODE=0.
REQ-016 In IDLE: in_ready=1; an accepted symbol with in_sof SHALL load step(0xFFFFFFFF, in_data) and go to DATA; accepted symbols without in_sof SHALL be dropped and not forwarded.
REQ-017 In DATA: each accepted symbol SHALL update the CRC; an accepted in_sof SHALL abandon the current frame and reinitialise as in REQ-016.
REQ-018 An accepted in_eof (including sof and eof together) SHALL go to FCS when MODE=0, or to IDLE when MODE=1.
REQ-019 Accepted symbols SHALL appear on out_valid/out_data exactly 1 cycle after acceptance.
REQ-020 In FCS: in_ready=0; the block SHALL emit ~CRC, DATA_W bits per cycle, LSB-first, for 32/DATA_W consecutive cycles directly following the eof symbol on the output; out_last=1 on the final FCS symbol only; then go to IDLE.
REQ-021 crc_out SHALL equal ~CRC register, updated 1 cycle after each accept, and SHALL hold its value during FCS and IDLE.
REQ-022 MODE=1: out_last SHALL mark the forwarded eof symbol; after the eof update the register SHALL be compared against residue 0xDEBB20E3.
REQ-023 MODE=1: fcs_done SHALL pulse 1 cycle after eof acceptance; fcs_ok SHALL be the comparison result, held until the next fcs_done.
REQ-024 MODE=0: fcs_done and fcs_ok SHALL remain 0.

Reset
REQ-025 While reset is high: state IDLE, CRC register 0xFFFFFFFF (crc_out 0), out_valid/out_data/out_last/fcs_done/fcs_ok/err_cnt 0; input symbols ignored.
REQ-026 Reset during DATA or FCS SHALL abort the frame with no further FCS symbols and no out_last; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With ETH_FCS_ERR_CNT_EN defined and MODE=1: err_cnt SHALL increment on each fcs_done with fcs_ok=0, saturating at 0xFFFF.
REQ-028 Without ETH_FCS_ERR_CNT_EN: err_cnt SHALL be tied to 0, with no counter flops.

Verification
REQ-029 DATA_W=8, MODE=0, bytes 0x31..0x39 (sof first, eof last) -> crc_out 0xCBF43926; FCS symbols 0x26,0x39,0xF4,0xCB; out_last on 0xCB.
REQ-030 DATA_W=2, MODE=0, same bytes as 36 dibits LSB-first -> crc_out 0xCBF43926; 16 FCS dibits; in_ready low exactly 16 cycles.
REQ-031 DATA_W=2, MODE=1, 36 dibits plus 16 FCS dibits from REQ-030 -> single fcs_done pulse; fcs_ok=1; err_cnt unchanged.
REQ-032 MODE=1, same frame with payload bit 0 flipped -> fcs_ok=0; err_cnt=1 with the macro, 0 without.
REQ-033 MODE=0, reset in 2nd FCS cycle -> next cycle: out_valid=0, crc_out=0, in_ready=1; the following frame yields a correct FCS.
REQ-034 MODE=0, in_valid gaps plus a re-asserted in_sof mid-frame -> crc_out and FCS equal those of the second frame alone.
